// File: rtl/edge_scan_arbiter.sv
// Round-robin shared serial 0->1 transition detector: grants one requester, scans its word LSB-first.
// Optional falling-transition count is built when EDGE_SCAN_FALLING_EN is defined; otherwise fall_count is 0.
module edge_scan_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          edge_count,
  output logic [CNT_W-1:0]          fall_count
);

  localparam int BC_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {D_A, D_B, D_C} det_t;

  state_t r_state, w_state_nxt;
  det_t   r_det, w_det_nxt;

  logic [DATA_W-1:0]  r_shreg;
  logic [BC_W-1:0]    r_bitcnt;
  logic [ID_W-1:0]    r_rr;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_rise;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic [CNT_W-1:0]   r_edge_q;

  logic               w_any;
  logic [ID_W-1:0]    w_sel;
  logic               w_bit;
  logic               w_rise;
  logic               w_last;
  logic [ID_W-1:0]    w_rr_nxt;

  // Arbiter: first set request at or after the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    logic [ID_W-1:0] idx;
    w_any = 1'b0;
    w_sel = '0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = ID_W'(j);
      if (!w_any && req[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

  assign w_bit    = r_shreg[0];
  assign w_last   = (r_bitcnt == BC_W'(DATA_W - 1));
  assign w_rr_nxt = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

`ifdef EDGE_SCAN_FALLING_EN
  logic             w_fall;
  logic [CNT_W-1:0] r_fall;
  logic [CNT_W-1:0] r_fall_q;
`endif

  // Detector: A start, B last bit 0, C last bit 1.
  always_comb begin
    w_det_nxt = D_A;
    w_rise    = 1'b0;
`ifdef EDGE_SCAN_FALLING_EN
    w_fall    = 1'b0;
`endif
    case (r_det)
      D_A: w_det_nxt = w_bit ? D_C : D_B;
      D_B: begin
        w_det_nxt = w_bit ? D_C : D_B;
        w_rise    = w_bit;
      end
      D_C: begin
        w_det_nxt = w_bit ? D_C : D_B;
`ifdef EDGE_SCAN_FALLING_EN
        w_fall    = !w_bit;
`endif
      end
      default: w_det_nxt = D_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_det     <= D_A;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_rr      <= '0;
      r_id      <= '0;
      r_rise    <= '0;
      r_grant   <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_edge_q  <= '0;
    end else begin
      r_grant <= '0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_shreg  <= data_in[w_sel*DATA_W +: DATA_W];
          r_grant  <= NUM_REQ'(1) << w_sel;
          r_id     <= w_sel;
          r_bitcnt <= '0;
          r_rise   <= '0;
          r_det    <= D_A;
        end
        S_SHIFT: begin
          r_shreg  <= r_shreg >> 1;
          r_bitcnt <= r_bitcnt + 1'b1;
          r_det    <= w_det_nxt;
          if (w_rise) r_rise <= r_rise + 1'b1;
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_done_id <= r_id;
          r_edge_q  <= r_rise;
          r_rr      <= w_rr_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef EDGE_SCAN_FALLING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fall   <= '0;
      r_fall_q <= '0;
    end else begin
      if (r_state == S_IDLE && w_any)            r_fall   <= '0;
      else if (r_state == S_SHIFT && w_fall)     r_fall   <= r_fall + 1'b1;
      if (r_state == S_DONE)                     r_fall_q <= r_fall;
    end
  end
  assign fall_count = r_fall_q;
`else
  assign fall_count = '0;
`endif

  assign grant      = r_grant;
  assign done       = r_done;
  assign done_id    = r_done_id;
  assign edge_count = r_edge_q;

endmodule

// File: tb/tb_edge_scan_arbiter.sv
// Directed bench for edge_scan_arbiter: latency, counts, round-robin order, reset abort, ignored pulses.
module tb_edge_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  edge_count;
  logic [3:0]  fall_count;

  int errors = 0;
  int checks = 0;
  int n;
  int gcyc;
  int cyc = 0;
  int cnt;

  edge_scan_arbiter #(.NUM_REQ(4), .ID_W(2), .DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id),
    .edge_count(edge_count), .fall_count(fall_count)
  );

  always #5 clk = ~clk;

`ifdef EDGE_SCAN_FALLING_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(output int k);
    k = 0;
    while (grant == 4'b0 && k < 40) begin tick(); k++; end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 40) begin tick(); k++; end
  endtask

  task automatic run_job(input int id, input logic [7:0] word,
                         input int exp_rise, input int exp_fall, input string tag);
    int k;
    req[id] = 1'b1;
    data_in[id*8 +: 8] = word;
    wait_grant(k);
    check({tag, "_grant"}, {28'b0, grant}, 32'(4'b1 << id));
    check({tag, "_busy"}, {31'b0, busy}, 1);
    req[id] = 1'b0;
    wait_done(k);
    check({tag, "_lat"}, k, 9);
    check({tag, "_id"}, {30'b0, done_id}, id);
    check({tag, "_rise"}, {28'b0, edge_count}, exp_rise);
    check({tag, "_fall"}, {28'b0, fall_count}, FALL_EN ? exp_fall : 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b0;
    data_in = 32'b0;
    do_reset();
    check("rst_grant", {28'b0, grant}, 0);
    check("rst_busy",  {31'b0, busy}, 0);
    check("rst_done",  {31'b0, done}, 0);
    check("rst_id",    {30'b0, done_id}, 0);
    check("rst_rise",  {28'b0, edge_count}, 0);
    check("rst_fall",  {28'b0, fall_count}, 0);

    run_job(0, 8'h55, 3, 4, "j55");
    tick();
    check("done_pulse", {31'b0, done}, 0);
    check("hold_rise",  {28'b0, edge_count}, 3);
    check("idle_busy",  {31'b0, busy}, 0);

    run_job(1, 8'h00, 0, 0, "j00");
    run_job(1, 8'hFF, 0, 0, "jFF");
    run_job(1, 8'h0F, 0, 1, "j0F");
    run_job(1, 8'hF0, 1, 0, "jF0");

    // Round robin from pointer 0 with all four requesting.
    do_reset();
    data_in = {8'h01, 8'h03, 8'h05, 8'h07};
    req = 4'b1111;
    gcyc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(n);
      check($sformatf("rr_grant%0d", i), {28'b0, grant}, 32'(4'b1 << i));
      if (i > 0) check($sformatf("rr_space%0d", i), cyc - gcyc, 10);
      gcyc = cyc;
      req[i] = 1'b0;
      wait_done(n);
      check($sformatf("rr_done%0d", i), {30'b0, done_id}, i);
    end

    // Pointer wraps from 3 back to 0.
    run_job(2, 8'h02, 1, 1, "j2");
    req = 4'b0101;
    wait_grant(n);
    check("wrap_g0", {28'b0, grant}, 32'b0001);
    req[0] = 1'b0;
    wait_done(n);
    wait_grant(n);
    check("wrap_g2", {28'b0, grant}, 32'b0100);
    req[2] = 1'b0;
    wait_done(n);
    check("wrap_id", {30'b0, done_id}, 2);

    // One-cycle request while busy is never granted.
    req[0] = 1'b1;
    data_in[7:0] = 8'hAA;
    wait_grant(n);
    req[0] = 1'b0;
    tick(); tick();
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    wait_done(n);
    check("pulse_rise", {28'b0, edge_count}, 4);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (grant != 4'b0) cnt++; end
    check("pulse_nogrant", cnt, 0);

    // Reset while the 4th bit is being scanned aborts the job.
    req[1] = 1'b1;
    data_in[15:8] = 8'h55;
    wait_grant(n);
    req[1] = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_rise", {28'b0, edge_count}, 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (done) cnt++; end
    check("abort_nodone", cnt, 0);
    run_job(1, 8'h55, 3, 4, "post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
